i2c_regmap_slave: RTL and testbench

Parametrised I2C target (slave) exposing a byte-addressed register map. It has N_RD read-only bytes sampled from fabric and N_WR writable control bytes driven back into fabric. It adds to the single-status-byte slave:
- a register pointer with auto-increment
- master writes
- repeated START
- coherent multi-byte reads

It sits between the SCL/SDA pads (uio open-drain wiring) and the design core (position tracker, status, control).

---
 rtl/i2c_regmap_slave.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_i2c_regmap_slave.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regmap_slave.sv
// ----------------------------------------------------------------------------
// i2c_regmap_slave
//
// I2C target exposing a byte-addressed register map to an I2C master.
//   registers 0 .. N_RD-1            : read-only bytes sampled from rd_bus
//   registers N_RD .. N_RD+N_WR-1    : writable control bytes on wr_regs
//   anything beyond                   : reads as 8'hFF, writes are discarded
// An 8-bit register pointer (set by the first data byte of a write, then
// auto-incremented per byte, modulo 256) is kept across transactions, so a
// "write pointer, repeated START, read" sequence works.
//
// Optional feature (compile-time macro I2C_REGMAP_SNAPSHOT_EN):
//   defined   : all of rd_bus is captured into a shadow register on a
//               read-address match; every byte of that read comes from the
//               shadow, so multi-byte reads are coherent.
//   undefined : each byte is taken live from rd_bus when it is loaded.
//
// Ports:
//   clk        in   system clock (single domain, >= 16x SCL)
//   rst_n      in   asynchronous active-low reset
//   scl_in     in   SCL from pad (asynchronous)
//   sda_in     in   SDA from pad (asynchronous)
//   sda_oe     out  1 = pull SDA low, 0 = release
//   rd_bus     in   read-only bytes, rd_bus[7:0] is register 0
//   wr_regs    out  writable bytes, wr_regs[7:0] is register N_RD
//   wr_strobe  out  one-clk pulse per byte written, one bit per byte
//   busy       out  high from an accepted START until STOP, mismatch, reset
// ----------------------------------------------------------------------------
module i2c_regmap_slave #(
  parameter logic [6:0] I2C_ADDR = 7'h64,
  parameter int         N_RD     = 4,
  parameter int         N_WR     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_oe,
  input  logic [8*N_RD-1:0]   rd_bus,
  output logic [8*N_WR-1:0]   wr_regs,
  output logic [N_WR-1:0]     wr_strobe,
  output logic                busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_MACK,
    S_WAIT
  } state_t;

  // Read value of register p: live/shadow read bytes, writable readback, or FF.
  function automatic logic [7:0] f_read_byte(
    input logic [7:0]        p,
    input logic [8*N_RD-1:0] rd,
    input logic [8*N_WR-1:0] wr
  );
    logic [7:0] v;
    v = 8'hFF;
    for (int i = 0; i < N_RD; i++) begin
      if (p == 8'(i)) v = rd[8*i +: 8];
    end
    for (int i = 0; i < N_WR; i++) begin
      if (p == 8'(N_RD + i)) v = wr[8*i +: 8];
    end
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Pad synchronisers and edge detect. Idle bus level is high, so the chain
  // resets to 1 to avoid a phantom START/STOP right after reset.
  // --------------------------------------------------------------------------
  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // SDA transitions are only bus conditions while SCL is stably high.
  assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
  assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;

  // --------------------------------------------------------------------------
  // Protocol state
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic [3:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic [7:0]         r_ptr;
  logic               r_ack_on;
  logic               r_rw;
  logic               r_sda_oe;
  logic [8*N_WR-1:0]  r_wr_regs;
  logic [N_WR-1:0]    r_wr_strobe;

  state_t             w_state_nxt;
  logic [3:0]         w_cnt_nxt;
  logic [7:0]         w_shift_nxt;
  logic [7:0]         w_ptr_nxt;
  logic               w_ack_on_nxt;
  logic               w_rw_nxt;
  logic               w_oe_nxt;
  logic [8*N_WR-1:0]  w_wr_regs_nxt;
  logic [N_WR-1:0]    w_strobe_nxt;

  logic [7:0]         w_rx_byte;
  logic [7:0]         w_ptr_inc;
  logic [3:0]         w_cnt_inc;
  logic [2:0]         w_bit_idx;
  logic [8*N_RD-1:0]  w_rd_src;
  logic [7:0]         w_rd_cur;
  logic [7:0]         w_rd_nxt;

  // Byte as it stands after shifting in the bit sampled on this SCL rise.
  assign w_rx_byte = {r_shift[6:0], r_sda_s2};
  assign w_ptr_inc = r_ptr + 8'd1;
  assign w_cnt_inc = r_bit_cnt + 4'd1;
  // r_bit_cnt counts read bits already clocked out; next bit is MSB-first.
  assign w_bit_idx = 3'd7 - r_bit_cnt[2:0];

`ifdef I2C_REGMAP_SNAPSHOT_EN
  logic [8*N_RD-1:0] r_snap;
  logic              w_snap_take;

  assign w_snap_take = (r_state == S_ADDR) && w_scl_rise && !w_start && !w_stop &&
                       (r_bit_cnt == 4'd7) && (w_rx_byte == {I2C_ADDR, 1'b1});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
    end else if (w_snap_take) begin
      r_snap <= rd_bus;
    end
  end

  assign w_rd_src = r_snap;
`else
  assign w_rd_src = rd_bus;
`endif

  assign w_rd_cur = f_read_byte(r_ptr, w_rd_src, r_wr_regs);
  assign w_rd_nxt = f_read_byte(w_ptr_inc, w_rd_src, r_wr_regs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_ack_on    <= 1'b0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_wr_regs   <= '0;
      r_wr_strobe <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_ack_on    <= w_ack_on_nxt;
      r_rw        <= w_rw_nxt;
      r_sda_oe    <= w_oe_nxt;
      r_wr_regs   <= w_wr_regs_nxt;
      r_wr_strobe <= w_strobe_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_ack_on_nxt  = r_ack_on;
    w_rw_nxt      = r_rw;
    w_oe_nxt      = r_sda_oe;
    w_wr_regs_nxt = r_wr_regs;
    w_strobe_nxt  = '0;

    // Bus conditions win over bit processing in the same cycle.
    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_oe_nxt     = 1'b0;
      w_ack_on_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_cnt_nxt    = '0;
      w_oe_nxt     = 1'b0;
      w_ack_on_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_WAIT: begin
          w_oe_nxt = 1'b0;
        end

        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_rx_byte;
            w_cnt_nxt   = w_cnt_inc;
            if (r_bit_cnt == 4'd7) begin
              if (w_rx_byte[7:1] == I2C_ADDR) begin
                w_rw_nxt     = w_rx_byte[0];
                w_ack_on_nxt = 1'b0;
                w_state_nxt  = S_ADDR_ACK;
              end else begin
                w_state_nxt  = S_WAIT;
              end
            end
          end
        end

        // ACK window: first SCL fall (8th) pulls SDA, second (9th) ends it.
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_oe_nxt     = 1'b1;
              w_ack_on_nxt = 1'b1;
            end else begin
              w_ack_on_nxt = 1'b0;
              w_cnt_nxt    = '0;
              if (r_rw) begin
                // First read bit goes out on the same fall that ends the ACK.
                w_shift_nxt = w_rd_cur;
                w_oe_nxt    = ~w_rd_cur[7];
                w_state_nxt = S_RDATA;
              end else begin
                w_oe_nxt    = 1'b0;
                w_state_nxt = S_PTR;
              end
            end
          end
        end

        S_PTR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_rx_byte;
            w_cnt_nxt   = w_cnt_inc;
            if (r_bit_cnt == 4'd7) begin
              w_ptr_nxt    = w_rx_byte;
              w_ack_on_nxt = 1'b0;
              w_state_nxt  = S_PTR_ACK;
            end
          end
        end

        S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_oe_nxt     = 1'b1;
              w_ack_on_nxt = 1'b1;
            end else begin
              w_oe_nxt     = 1'b0;
              w_ack_on_nxt = 1'b0;
              w_cnt_nxt    = '0;
              w_state_nxt  = S_WDATA;
            end
          end
        end

        S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_rx_byte;
            w_cnt_nxt   = w_cnt_inc;
            if (r_bit_cnt == 4'd7) begin
              for (int i = 0; i < N_WR; i++) begin
                if (r_ptr == 8'(N_RD + i)) begin
                  w_wr_regs_nxt[8*i +: 8] = w_rx_byte;
                  w_strobe_nxt[i]         = 1'b1;
                end
              end
              w_ptr_nxt    = w_ptr_inc;
              w_ack_on_nxt = 1'b0;
              w_state_nxt  = S_WDATA_ACK;
            end
          end
        end

        S_RDATA: begin
          if (w_scl_rise) begin
            if (r_bit_cnt != 4'd8) w_cnt_nxt = w_cnt_inc;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = S_RDATA_MACK;
            end else begin
              w_oe_nxt    = ~r_shift[w_bit_idx];
            end
          end
        end

        S_RDATA_MACK: begin
          if (w_scl_rise) begin
            if (!r_sda_s2) begin
              // Master ACK: next byte is driven from the following SCL fall.
              w_ptr_nxt   = w_ptr_inc;
              w_shift_nxt = w_rd_nxt;
              w_cnt_nxt   = '0;
              w_state_nxt = S_RDATA;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_oe_nxt    = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe    = r_sda_oe;
  assign wr_regs   = r_wr_regs;
  assign wr_strobe = r_wr_strobe;
  assign busy      = (r_state != S_IDLE) && (r_state != S_WAIT);

endmodule

// File: tb/tb_i2c_regmap_slave.sv
// ----------------------------------------------------------------------------
// tb_i2c_regmap_slave
//
// Bench for i2c_regmap_slave: a behavioural I2C master drives the pads
// (open-drain wired-AND with the target's sda_oe), and a register-map model
// (pointer, writable bytes, optional read snapshot) predicts every ACK,
// read byte, wr_regs value and strobe count. Directed sequences are followed
// by randomized transactions.
// ----------------------------------------------------------------------------
module tb_i2c_regmap_slave;

  localparam int  N_RD = 4;
  localparam int  N_WR = 2;
  localparam time Q    = 50ns;   // quarter SCL period (SCL = clk/20)

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [31:0] rd_bus = 32'h0;
  logic        sda_line;
  logic        sda_oe;
  logic        busy;
  logic [15:0] wr_regs;
  logic [1:0]  wr_strobe;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_regmap_slave #(
    .I2C_ADDR (7'h64),
    .N_RD     (N_RD),
    .N_WR     (N_WR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .rd_bus    (rd_bus),
    .wr_regs   (wr_regs),
    .wr_strobe (wr_strobe),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- monitors (sampled on negedge, away from active edge) ----
  logic   strb_clr = 1'b1;
  logic   mon_en   = 1'b0;
  int     strb_cnt0, strb_cnt1;
  longint first_t0, first_t1, cyc;
  logic   strb_overlap, oe_seen;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (strb_clr) begin
      strb_cnt0    <= 0;
      strb_cnt1    <= 0;
      first_t0     <= -1;
      first_t1     <= -1;
      strb_overlap <= 1'b0;
    end else begin
      if (wr_strobe[0]) begin
        strb_cnt0 <= strb_cnt0 + 1;
        if (first_t0 < 0) first_t0 <= cyc;
      end
      if (wr_strobe[1]) begin
        strb_cnt1 <= strb_cnt1 + 1;
        if (first_t1 < 0) first_t1 <= cyc;
      end
      if (wr_strobe == 2'b11) strb_overlap <= 1'b1;
    end
    if (!mon_en) oe_seen <= 1'b0;
    else if (sda_oe) oe_seen <= 1'b1;
  end

  initial cyc = 0;

  // ---------------- reference model ----------------------------------------
  int         m_ptr = 0;
  logic [7:0] m_wr [N_WR];
  int         exp_cnt [N_WR];
  logic [7:0] wbuf [8];
  logic [7:0] rx [8];

  function automatic logic [7:0] m_read(input int p, input logic [31:0] src);
    if (p < N_RD) return src[8*p +: 8];
    else if (p < N_RD + N_WR) return m_wr[p - N_RD];
    return 8'hFF;
  endfunction

  // ---------------- bus master primitives -----------------------------------
  task automatic i2c_start();   // also serves as repeated START from SCL low
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit acked);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    acked = (sda_line == 1'b0);
    #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic recv_bits(output logic [7:0] b);
    sda_m = 1'b1;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #Q; scl_m = 1'b1;
      #Q; b = {b[6:0], sda_line};
      #Q; scl_m = 1'b0;
      #Q;
    end
  endtask

  task automatic master_ack(input bit nack);
    sda_m = nack; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
    sda_m = 1'b1;
  endtask

  // ---------------- transactions --------------------------------------------
  task automatic do_write(input logic [7:0] p, input int n);
    bit a;
    strb_clr = 1'b1; #20; strb_clr = 1'b0;
    for (int i = 0; i < N_WR; i++) exp_cnt[i] = 0;
    i2c_start();
    chk("wr_busy_start", busy, 1);
    send_byte(8'hC8, a); chk("wr_addr_ack", a, 1);
    send_byte(p, a);     chk("wr_ptr_ack", a, 1);
    m_ptr = p;
    for (int k = 0; k < n; k++) begin
      send_byte(wbuf[k], a); chk("wr_data_ack", a, 1);
      if (m_ptr >= N_RD && m_ptr < N_RD + N_WR) begin
        m_wr[m_ptr - N_RD] = wbuf[k];
        exp_cnt[m_ptr - N_RD]++;
      end
      m_ptr = (m_ptr + 1) % 256;
    end
    i2c_stop();
    chk("wr_busy_stop", busy, 0);
    chk("wr_regs", {16'h0, wr_regs}, {16'h0, m_wr[1], m_wr[0]});
    chk("wr_strobe0_cnt", strb_cnt0, exp_cnt[0]);
    chk("wr_strobe1_cnt", strb_cnt1, exp_cnt[1]);
    chk("wr_strobe_overlap", strb_overlap, 0);
  endtask

  // chg: 0 = rd_bus constant, 1 = random change before each master ACK,
  //      2 = change to 32'hDDCCBBAA before the first master ACK only
  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n, input int chg);
    bit a;
    logic [7:0] b, e;
    logic [31:0] snap;
    i2c_start();
    chk("rd_busy_start", busy, 1);
    if (set_ptr) begin
      send_byte(8'hC8, a); chk("rd_waddr_ack", a, 1);
      send_byte(p, a);     chk("rd_ptr_ack", a, 1);
      m_ptr = p;
      i2c_start();
    end
    snap = rd_bus;
    send_byte(8'hC9, a); chk("rd_raddr_ack", a, 1);
    for (int k = 0; k < n; k++) begin
`ifdef I2C_REGMAP_SNAPSHOT_EN
      e = m_read(m_ptr, snap);
`else
      e = m_read(m_ptr, rd_bus);
`endif
      recv_bits(b);
      rx[k] = b;
      chk("rd_data", b, e);
      if (k < n - 1) begin
        if (chg == 1) rd_bus = $urandom;
        else if (chg == 2 && k == 0) rd_bus = 32'hDDCCBBAA;
        master_ack(1'b0);
        m_ptr = (m_ptr + 1) % 256;
      end else begin
        master_ack(1'b1);
      end
    end
    chk("rd_oe_after_nack", sda_oe, 0);
    chk("rd_busy_after_nack", busy, 0);
    i2c_stop();
  endtask

  task automatic do_badaddr(input logic [6:0] ad, input bit rw);
    bit a;
    mon_en = 1'b1;
    i2c_start();
    send_byte({ad, rw}, a);  chk("bad_addr_nack", a, 0);
    chk("bad_busy", busy, 0);
    send_byte(8'($urandom), a); chk("bad_data_nack", a, 0);
    i2c_stop();
    chk("bad_oe_never", oe_seen, 0);
    mon_en = 1'b0;
    #20;
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    bit a;
    logic [7:0] b;
    logic [15:0] wr_before;
    logic [6:0] bad;
    int n;
    logic [7:0] p;

    for (int i = 0; i < N_WR; i++) m_wr[i] = 8'h00;
    #100;
    rst_n = 1'b1;
    #100;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_regs", {16'h0, wr_regs}, 32'h0);
    chk("rst_wr_strobe", {30'h0, wr_strobe}, 32'h0);

    // Directed write of two control bytes.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    do_write(8'h04, 2);
    chk("dir_wr_regs", {16'h0, wr_regs}, 32'h00003CA5);
    chk("dir_strobe_order", (first_t0 >= 0) && (first_t0 < first_t1), 1);

    // Pointer write, repeated START, 4-byte read.
    rd_bus = 32'h44332211;
    do_read(1'b1, 8'h00, 4, 0);
    chk("dir_rd_b0", rx[0], 8'h11);
    chk("dir_rd_b1", rx[1], 8'h22);
    chk("dir_rd_b2", rx[2], 8'h33);
    chk("dir_rd_b3", rx[3], 8'h44);

    // rd_bus changes after byte 1.
    rd_bus = 32'h44332211;
    do_read(1'b1, 8'h00, 4, 2);
    chk("snap_b0", rx[0], 8'h11);
`ifdef I2C_REGMAP_SNAPSHOT_EN
    chk("snap_b1", rx[1], 8'h22);
    chk("snap_b2", rx[2], 8'h33);
    chk("snap_b3", rx[3], 8'h44);
`else
    chk("snap_b1", rx[1], 8'hBB);
    chk("snap_b2", rx[2], 8'hCC);
    chk("snap_b3", rx[3], 8'hDD);
`endif

    // Foreign address.
    do_badaddr(7'h50, 1'b0);

    // Read beyond the map.
    do_read(1'b1, 8'h06, 1, 0);
    chk("dir_rd_beyond", rx[0], 8'hFF);

    // Write beyond the map: ACKed, discarded.
    wr_before = wr_regs;
    wbuf[0] = 8'h55;
    do_write(8'h10, 1);
    chk("dir_wr_beyond_regs", {16'h0, wr_regs}, {16'h0, wr_before});
    chk("dir_wr_beyond_strb", strb_cnt0 + strb_cnt1, 0);

    // Pointer wrap 0xFF -> 0x00.
    rd_bus = 32'h87654321;
    do_read(1'b1, 8'hFF, 2, 0);
    chk("dir_wrap_b0", rx[0], 8'hFF);
    chk("dir_wrap_b1", rx[1], 8'h21);

    // Reset in the middle of a read while the target pulls SDA low.
    rd_bus = 32'h00000000;
    i2c_start();
    send_byte(8'hC8, a);
    send_byte(8'h00, a);
    i2c_start();
    send_byte(8'hC9, a); chk("mid_rst_addr_ack", a, 1);
    #Q;
    chk("mid_rst_oe_before", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", sda_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_regs", {16'h0, wr_regs}, 32'h0);
    #9;
    scl_m = 1'b1; sda_m = 1'b1;
    #100;
    rst_n = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < N_WR; i++) m_wr[i] = 8'h00;
    #100;
    chk("post_rst_busy", busy, 0);
    rd_bus = 32'hCAFEF00D;
    do_read(1'b0, 8'h00, 2, 0);   // pointer must be back at 0

    // Randomized transactions against the model.
    for (int t = 0; t < 30; t++) begin
      rd_bus = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          n = $urandom_range(0, 3);
          for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
          p = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
          do_write(p, n);
        end
        1: begin
          p = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
          do_read(1'b1, p, $urandom_range(1, 4), 1);
        end
        2: do_read(1'b0, 8'h00, $urandom_range(1, 3), $urandom_range(0, 1));
        default: begin
          bad = 7'($urandom);
          if (bad == 7'h64) bad = 7'h65;
          do_badaddr(bad, 1'($urandom));
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
